// File: rtl/pb_cmd_pkg.sv
// Shared types and default timing for the pushbutton command decoder.
// Defaults assume a 50 MHz core clock: 1 ms bounce lockout, 0.5 s double-press window.
package pb_cmd_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOCKOUT1 = 2'd1,
        WAIT2    = 2'd2,
        LOCKOUT2 = 2'd3
    } pb_state_t;

    localparam int LOCKOUT_CYC_DEF = 50_000;
    localparam int DBL_WIN_CYC_DEF = 25_000_000;

endpackage

// File: rtl/pb_cmd_decode.sv
// Classifies button releases as single press (toggle power) or double press (force power off).
// Latency: single after lockout+window cycles; double in the cycle after the second release. No backpressure.
module pb_cmd_decode
    import pb_cmd_pkg::*;
#(
    parameter int LOCKOUT_CYC = LOCKOUT_CYC_DEF,
    parameter int DBL_WIN_CYC = DBL_WIN_CYC_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic released,
    output logic pwr_up,
    output logic single_pb,
    output logic double_pb
);

    localparam int MAX_CYC = (LOCKOUT_CYC > DBL_WIN_CYC) ? LOCKOUT_CYC : DBL_WIN_CYC;
    localparam int TW      = $clog2(MAX_CYC);

    localparam logic [TW-1:0] LOCK_LD = TW'(LOCKOUT_CYC - 1);
    localparam logic [TW-1:0] WIN_LD  = TW'(DBL_WIN_CYC - 1);

    pb_state_t     state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          pwr_q, pwr_d;
    logic          single_q, single_d;
    logic          double_q, double_d;

    logic          tmr_zero;
    logic [TW-1:0] tmr_dec;

    // The shared timer saturates at zero so it can never wrap.
    assign tmr_zero = (timer_q == '0);
    assign tmr_dec  = tmr_zero ? timer_q : (timer_q - TW'(1));

    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pwr_d    = pwr_q;
        single_d = 1'b0;
        double_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (released) begin
                    state_d = LOCKOUT1;
                    timer_d = LOCK_LD;
                end
            end
            LOCKOUT1: begin
                if (tmr_zero) begin
                    state_d = WAIT2;
                    timer_d = WIN_LD;
                end else begin
                    timer_d = tmr_dec;
                end
            end
            WAIT2: begin
                // A release on the expiry edge still wins as a double press.
                if (released) begin
                    state_d  = LOCKOUT2;
                    timer_d  = LOCK_LD;
                    double_d = 1'b1;
                    pwr_d    = 1'b0;
                end else if (tmr_zero) begin
                    state_d  = IDLE;
                    single_d = 1'b1;
                    pwr_d    = ~pwr_q;
                end else begin
                    timer_d = tmr_dec;
                end
            end
            LOCKOUT2: begin
                if (tmr_zero) begin
                    state_d = IDLE;
                end else begin
                    timer_d = tmr_dec;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            pwr_q    <= 1'b0;
            single_q <= 1'b0;
            double_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            pwr_q    <= pwr_d;
            single_q <= single_d;
            double_q <= double_d;
        end
    end

    assign pwr_up    = pwr_q;
    assign single_pb = single_q;
    assign double_pb = double_q;

endmodule

// File: tb/tb_pb_cmd_decode.sv
// Bench for pb_cmd_decode: directed press scenarios plus random releases/resets,
// checked every cycle against a timestamp-based model of the press classification rules.
module tb_pb_cmd_decode;
    import pb_cmd_pkg::*;

    localparam int L = 4;
    localparam int D = 10;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic released = 1'b0;
    logic pwr_up, single_pb, double_pb;

    int tests = 0;
    int fails = 0;

    // Model: a sequence starts at edge e0; the window is e0+L+1 .. e0+L+D.
    int m_n = 0;
    int m_e0 = 0;
    int m_ready = 0;
    bit m_in_seq = 1'b0;
    bit m_pwr = 1'b0;
    bit m_single = 1'b0;
    bit m_double = 1'b0;

    int n_single, n_double;

    pb_cmd_decode #(.LOCKOUT_CYC(L), .DBL_WIN_CYC(D)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .released  (released),
        .pwr_up    (pwr_up),
        .single_pb (single_pb),
        .double_pb (double_pb)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_in_seq = 1'b0;
        m_pwr    = 1'b0;
        m_single = 1'b0;
        m_double = 1'b0;
        m_ready  = 0;
    endtask

    task automatic model_edge(input int n, input bit r);
        m_single = 1'b0;
        m_double = 1'b0;
        if (m_in_seq) begin
            if (r && n >= m_e0 + L + 1 && n <= m_e0 + L + D) begin
                m_double = 1'b1;
                m_pwr    = 1'b0;
                m_in_seq = 1'b0;
                m_ready  = n + L + 1;
            end else if (n == m_e0 + L + D) begin
                m_single = 1'b1;
                m_pwr    = ~m_pwr;
                m_in_seq = 1'b0;
                m_ready  = n + 1;
            end
        end else if (r && n >= m_ready) begin
            m_in_seq = 1'b1;
            m_e0     = n;
        end
    endtask

    // Drive one edge worth of stimulus and advance the model; outputs settle by return.
    task automatic step(input bit r);
        released = r;
        @(posedge clk);
        m_n++;
        if (!rst_n) model_reset();
        else model_edge(m_n, r);
        #1;
    endtask

    function automatic bit in_list(input int i, input int a, input int b, input int c, input int d);
        return (i == a) || (i == b) || (i == c) || (i == d);
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        model_reset();
        for (int i = 0; i < 3; i++) begin
            step(i[0]);
            tests++;
            if ({pwr_up, single_pb, double_pb} !== 3'b000) begin
                fails++;
                $display("FAIL reset.outputs cyc %0d got %b%b%b exp 000", i, pwr_up, single_pb, double_pb);
            end
        end
        released = 1'b0;
        rst_n = 1'b1;
        step(1'b0);
        tests++;
        if (dut.state_q !== IDLE) begin
            fails++;
            $display("FAIL reset.state got %0d exp %0d", dut.state_q, IDLE);
        end
    endtask

    task automatic test_single(input int a, input int b, input int c, input int ncyc, input string nm,
                               input int exp_s, input int exp_d, input bit exp_pwr);
        n_single = 0;
        n_double = 0;
        for (int i = 0; i < ncyc; i++) begin
            step(in_list(i, a, b, c, -1));
            n_single += int'(single_pb);
            n_double += int'(double_pb);
            tests++;
            if ({pwr_up, single_pb, double_pb} !== {m_pwr, m_single, m_double}) begin
                fails++;
                $display("FAIL %s.cycle %0d got pwr/s/d %b%b%b exp %b%b%b", nm, i,
                         pwr_up, single_pb, double_pb, m_pwr, m_single, m_double);
            end
        end
        tests++;
        if (n_single !== exp_s || n_double !== exp_d || pwr_up !== exp_pwr) begin
            fails++;
            $display("FAIL %s.summary got s=%0d d=%0d pwr=%b exp s=%0d d=%0d pwr=%b", nm,
                     n_single, n_double, pwr_up, exp_s, exp_d, exp_pwr);
        end
    endtask

    task automatic test_double();
        n_single = 0;
        n_double = 0;
        for (int i = 0; i < 50; i++) begin
            step(in_list(i, 20, 27, 29, 31));
            n_single += int'(single_pb);
            n_double += int'(double_pb);
            tests++;
            if ({pwr_up, single_pb, double_pb} !== {m_pwr, m_single, m_double}) begin
                fails++;
                $display("FAIL double.cycle %0d got pwr/s/d %b%b%b exp %b%b%b", i,
                         pwr_up, single_pb, double_pb, m_pwr, m_single, m_double);
            end
            if (i == 27) begin
                tests++;
                if (double_pb !== 1'b1 || pwr_up !== 1'b0) begin
                    fails++;
                    $display("FAIL double.at27 got d=%b pwr=%b exp d=1 pwr=0", double_pb, pwr_up);
                end
            end
        end
        tests++;
        if (n_single !== 0 || n_double !== 1) begin
            fails++;
            $display("FAIL double.summary got s=%0d d=%0d exp s=0 d=1", n_single, n_double);
        end
    endtask

    task automatic test_reset_mid();
        n_single = 0;
        n_double = 0;
        for (int i = 0; i < 40; i++) begin
            if (i == 26) rst_n = 1'b0;
            if (i == 29) rst_n = 1'b1;
            step(i == 20);
            n_single += int'(single_pb);
            n_double += int'(double_pb);
            tests++;
            if ({pwr_up, single_pb, double_pb} !== {m_pwr, m_single, m_double}) begin
                fails++;
                $display("FAIL reset_mid.cycle %0d got pwr/s/d %b%b%b exp %b%b%b", i,
                         pwr_up, single_pb, double_pb, m_pwr, m_single, m_double);
            end
        end
        tests++;
        if (n_single !== 0 || n_double !== 0 || pwr_up !== 1'b0 || dut.state_q !== IDLE) begin
            fails++;
            $display("FAIL reset_mid.summary got s=%0d d=%0d pwr=%b st=%0d exp 0 0 0 %0d",
                     n_single, n_double, pwr_up, dut.state_q, IDLE);
        end
    endtask

    task automatic test_random();
        bit r;
        for (int i = 0; i < 3000; i++) begin
            if (rst_n && $urandom_range(0, 599) == 0) rst_n = 1'b0;
            else if (!rst_n) rst_n = 1'b1;
            r = ($urandom_range(0, 9) == 0);
            step(r);
            tests++;
            if ({pwr_up, single_pb, double_pb} !== {m_pwr, m_single, m_double}) begin
                fails++;
                $display("FAIL random.cycle %0d got pwr/s/d %b%b%b exp %b%b%b", i,
                         pwr_up, single_pb, double_pb, m_pwr, m_single, m_double);
            end
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        // single press at 20 -> pulse after edge 34, power on; second press -> power off
        test_single(20, -1, -1, 40, "single1", 1, 0, 1'b1);
        test_single(20, -1, -1, 40, "single2", 1, 0, 1'b0);
        test_single(20, 21, 23, 40, "bounce", 1, 0, 1'b1);
        test_double();
        test_single(20, 34, -1, 45, "boundary", 0, 1, 1'b0);
        test_single(20, 24, -1, 40, "lockout_edge", 1, 0, 1'b1);
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pb_cmd_decode.md
# pb_cmd_decode

Consumes the one-cycle `released` pulse produced by the pushbutton release detector and classifies operator input as a single press or a double press. A single press toggles the rider power-enable level. A double press forces power off. Sits between the pushbutton front end and the power/enable logic of the Segway controller; a lockout window after every accepted release rejects residual bounce.

## Interface
- `LOCKOUT_CYC`, default 50_000: cycles after an accepted release during which further releases are ignored (1 ms at 50 MHz); must be ≥ 2.
- `DBL_WIN_CYC`, default 25_000_000: length in cycles of the second-press window after lockout (0.5 s at 50 MHz); must be ≥ 2.
- `clk`  input  1  system clock; all state updates on the rising edge.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `released`  input  1  one-cycle pulse per button release, already synchronized to `clk`.
- `pwr_up`  output  1  registered power-enable level.
- `single_pb`  output  1  registered one-cycle pulse when a single press is classified.
- `double_pb`  output  1  registered one-cycle pulse when a double press is classified.

## Operation
- Reset: state IDLE, timer 0, `pwr_up`=0, `single_pb`=0, `double_pb`=0. Reset asserted mid-sequence abandons the sequence with no pulse emitted.
- Four states:
  - IDLE: `released` sampled high → LOCKOUT1, timer loaded with LOCKOUT_CYC−1.
  - LOCKOUT1: `released` ignored. Timer decrements each edge. Timer==0 → WAIT2, timer loaded with DBL_WIN_CYC−1.
  - WAIT2: `released` sampled high → LOCKOUT2, timer loaded with LOCKOUT_CYC−1, `double_pb` pulsed, `pwr_up` cleared. Otherwise the timer decrements. Timer==0 with no release → IDLE, `single_pb` pulsed, `pwr_up` inverted.
  - LOCKOUT2: `released` ignored. Timer==0 → IDLE.
- A release and timer expiry on the same WAIT2 edge count as a double press; expiry is not also reported.
- `single_pb` and `double_pb` are never high in the same cycle, and each is high for exactly one cycle per event.
- `double_pb` while `pwr_up` is already 0 leaves `pwr_up` at 0.
- Timer width is $clog2 of the larger of LOCKOUT_CYC and DBL_WIN_CYC. The timer is unsigned and never wraps: it is only decremented while nonzero.

## Timing
- Let E0 be the edge that samples the first `released` in IDLE.
- WAIT2 is entered at edge E0+LOCKOUT_CYC.
- The second-press window covers the edges from E0+LOCKOUT_CYC+1 through E0+LOCKOUT_CYC+DBL_WIN_CYC inclusive.
- Single press: `single_pb` and the new `pwr_up` appear after edge E0+LOCKOUT_CYC+DBL_WIN_CYC. This is the classification latency.
- Double press: for a release sampled at edge E1 inside the window, `double_pb`=1 and `pwr_up`=0 appear after E1, i.e. 0 cycles of extra latency. IDLE is re-entered at E1+LOCKOUT_CYC.
- A new sequence can start on the first edge after IDLE is re-entered. A `released` on the very edge that returns to IDLE is ignored.

## Structure
- Shared package `pb_cmd_pkg` holds:
  - the state enum `pb_state_t` {IDLE, LOCKOUT1, WAIT2, LOCKOUT2};
  - the default cycle constants, so the top level and bench can override them consistently.
- One shared down-counter serves both windows and stays inline; no sub-module is warranted.
- Implementation: state register, timer, and output flops in one asynchronous-reset always_ff; next-state logic in always_comb.

## Test plan
Bench parameters: LOCKOUT_CYC=4, DBL_WIN_CYC=10.
- Reset held for 3 cycles with `released` toggling → all outputs 0; state IDLE after release of `rst_n`.
- Single `released` pulse at E0=20 → `single_pb` high for exactly one cycle after edge 34; `pwr_up` 0→1; a second single press later returns `pwr_up` to 0.
- Bounce: `released` at 20, 21, 23 (inside lockout) → treated as a single press; `single_pb` after edge 34; no `double_pb`.
- Double: with `pwr_up`=1, `released` at 20 and 27 → `double_pb` after edge 27, `pwr_up`=0, no `single_pb`; a `released` at 29 is ignored; IDLE at edge 31.
- Boundary: `released` at 20 and exactly 34 → `double_pb` after edge 34, no `single_pb`; a `released` at 24 (last lockout edge) alone → no action.
- Reset asserted at cycle 26 mid-WAIT2 → no pulses; `pwr_up`=0; IDLE.
